cluster_write_ctrl: RTL and testbench

Write-side controller for one sprite cluster. It accepts CPU write requests over a valid/ready port and buffers them in a FIFO. It drains them in order onto the cluster's single write port (`waddr`/`wdata`/`wen`). Position-register writes (sprite x/y/texture coords/size) are held until vertical blanking so a sprite never moves mid-frame; texture writes issue immediately. It sits between the GPU bus decoder and the `cluster` write port.

---
 rtl/gpu_pkg.sv | 20 ++
 rtl/sync_fifo.sv | 59 +++++
 rtl/cluster_write_ctrl.sv | 76 +++++++
 tb/tb_cluster_write_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// Shared GPU definitions: cluster register map constants, write payload type
// and the position-region address classifier.
package gpu_pkg;

    localparam int unsigned POSITION_WORDS = 6;
    localparam int unsigned GPU_ADDR_WIDTH = 16;
    localparam int unsigned GPU_INT_WIDTH  = 16;

    typedef struct packed {
        logic [GPU_ADDR_WIDTH-1:0] addr;
        logic [GPU_INT_WIDTH-1:0]  data;
    } cluster_wr_t;

    // Position registers occupy the first cluster_size*POSITION_WORDS addresses.
    function automatic logic is_position_addr(input logic [31:0] addr,
                                              input int unsigned cluster_size);
        return addr < 32'(cluster_size * POSITION_WORDS);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered pointers and a combinational head word.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned COUNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_en;
    logic             pop_en;

    assign full    = (count == COUNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_en = push && !full;
    assign pop_en  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_en) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_en, pop_en})
                2'b10:   count <= count + COUNT_W'(1);
                2'b01:   count <= count - COUNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cluster_write_ctrl.sv
// Buffers CPU writes to one sprite cluster and drains them in order, holding
// position-register writes until vertical blanking.
module cluster_write_ctrl
    import gpu_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 16,
    parameter int unsigned INT_WIDTH    = 16,
    parameter int unsigned CLUSTER_SIZE = 10,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [ADDR_WIDTH-1:0]           req_addr,
    input  logic [INT_WIDTH-1:0]            req_data,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic                            vblank,
    output logic [ADDR_WIDTH-1:0]           waddr,
    output logic [INT_WIDTH-1:0]            wdata,
    output logic                            wen,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] count,
    output logic                            stalled
);

    localparam int unsigned ENTRY_W = ADDR_WIDTH + INT_WIDTH;

    logic [ENTRY_W-1:0]    head;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [INT_WIDTH-1:0]  head_data;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  is_pos;
    logic                  issue;

    assign req_ready = !full && !rst;
    assign push      = req_valid && req_ready;

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({req_addr, req_data}),
        .pop       (issue),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    assign head_addr = head[ENTRY_W-1:INT_WIDTH];
    assign head_data = head[INT_WIDTH-1:0];
    assign is_pos    = is_position_addr(32'(head_addr), CLUSTER_SIZE);

    // A blocked position head also blocks everything behind it to keep CPU order.
    assign issue   = !rst && !empty && (!is_pos || vblank);
    assign stalled = !rst && !empty && is_pos && !vblank;

    always_ff @(posedge clk) begin
        if (rst) begin
            wen   <= 1'b0;
            waddr <= '0;
            wdata <= '0;
        end else begin
            wen <= issue;
            if (issue) begin
                waddr <= head_addr;
                wdata <= head_data;
            end
        end
    end

endmodule

// File: tb/tb_cluster_write_ctrl.sv
// Directed self-checking bench for cluster_write_ctrl.
module tb_cluster_write_ctrl;

    logic        clk;
    logic        rst;
    logic [15:0] req_addr;
    logic [15:0] req_data;
    logic        req_valid;
    logic        req_ready;
    logic        vblank;
    logic [15:0] waddr;
    logic [15:0] wdata;
    logic        wen;
    logic [3:0]  count;
    logic        stalled;

    int total;
    int bad;

    cluster_write_ctrl #(
        .ADDR_WIDTH   (16),
        .INT_WIDTH    (16),
        .CLUSTER_SIZE (10),
        .FIFO_DEPTH   (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .vblank    (vblank),
        .waddr     (waddr),
        .wdata     (wdata),
        .wen       (wen),
        .count     (count),
        .stalled   (stalled)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        total++; if (wen !== 1'b0)      begin bad++; $display("FAIL reset_wen got=%0b exp=0", wen); end
        total++; if (waddr !== 16'd0)   begin bad++; $display("FAIL reset_waddr got=%0d exp=0", waddr); end
        total++; if (wdata !== 16'd0)   begin bad++; $display("FAIL reset_wdata got=%0d exp=0", wdata); end
        total++; if (count !== 4'd0)    begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
        total++; if (stalled !== 1'b0)  begin bad++; $display("FAIL reset_stalled got=%0b exp=0", stalled); end
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%0b exp=0", req_ready); end
        rst = 1'b0;
        #1;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready got=%0b exp=1", req_ready); end
    endtask

    task automatic test_texture();
        vblank    = 1'b0;
        req_addr  = 16'd60;
        req_data  = 16'hABC;
        req_valid = 1'b1;
        #1;
        total++; if (stalled !== 1'b0) begin bad++; $display("FAIL tex_stalled_c0 got=%0b exp=0", stalled); end
        step();
        req_valid = 1'b0;
        #1;
        total++; if (wen !== 1'b0)     begin bad++; $display("FAIL tex_wen_c1 got=%0b exp=0", wen); end
        total++; if (count !== 4'd1)   begin bad++; $display("FAIL tex_count_c1 got=%0d exp=1", count); end
        total++; if (stalled !== 1'b0) begin bad++; $display("FAIL tex_stalled_c1 got=%0b exp=0", stalled); end
        step();
        total++; if (wen !== 1'b1)       begin bad++; $display("FAIL tex_wen_c2 got=%0b exp=1", wen); end
        total++; if (waddr !== 16'd60)   begin bad++; $display("FAIL tex_waddr got=%0d exp=60", waddr); end
        total++; if (wdata !== 16'hABC)  begin bad++; $display("FAIL tex_wdata got=%h exp=abc", wdata); end
        total++; if (count !== 4'd0)     begin bad++; $display("FAIL tex_count_c2 got=%0d exp=0", count); end
        step();
        total++; if (wen !== 1'b0) begin bad++; $display("FAIL tex_wen_c3 got=%0b exp=0", wen); end
    endtask

    task automatic test_position_hold();
        vblank    = 1'b0;
        req_addr  = 16'd3;
        req_data  = 16'd100;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        for (int c = 1; c < 50; c++) begin
            total++; if (wen !== 1'b0)     begin bad++; $display("FAIL hold_wen cyc=%0d got=%0b exp=0", c, wen); end
            total++; if (stalled !== 1'b1) begin bad++; $display("FAIL hold_stalled cyc=%0d got=%0b exp=1", c, stalled); end
            step();
        end
        vblank = 1'b1;
        #1;
        total++; if (stalled !== 1'b0) begin bad++; $display("FAIL hold_stalled_vb got=%0b exp=0", stalled); end
        total++; if (wen !== 1'b0)     begin bad++; $display("FAIL hold_wen_c50 got=%0b exp=0", wen); end
        step();
        total++; if (wen !== 1'b1)      begin bad++; $display("FAIL hold_wen_c51 got=%0b exp=1", wen); end
        total++; if (waddr !== 16'd3)   begin bad++; $display("FAIL hold_waddr got=%0d exp=3", waddr); end
        total++; if (wdata !== 16'd100) begin bad++; $display("FAIL hold_wdata got=%0d exp=100", wdata); end
        vblank = 1'b0;
        step();
        total++; if (wen !== 1'b0) begin bad++; $display("FAIL hold_wen_after got=%0b exp=0", wen); end
    endtask

    task automatic test_ordering();
        vblank    = 1'b0;
        req_valid = 1'b1;
        req_addr  = 16'd5;
        req_data  = 16'd11;
        step();
        req_addr  = 16'd70;
        req_data  = 16'd22;
        step();
        req_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            total++; if (wen !== 1'b0) begin bad++; $display("FAIL order_wen_blocked cyc=%0d got=%0b exp=0", c, wen); end
            step();
        end
        total++; if (count !== 4'd2)   begin bad++; $display("FAIL order_count got=%0d exp=2", count); end
        total++; if (stalled !== 1'b1) begin bad++; $display("FAIL order_stalled got=%0b exp=1", stalled); end
        vblank = 1'b1;
        step();
        total++; if (wen !== 1'b1 || waddr !== 16'd5 || wdata !== 16'd11)
            begin bad++; $display("FAIL order_first got=%0b/%0d/%0d exp=1/5/11", wen, waddr, wdata); end
        step();
        total++; if (wen !== 1'b1 || waddr !== 16'd70 || wdata !== 16'd22)
            begin bad++; $display("FAIL order_second got=%0b/%0d/%0d exp=1/70/22", wen, waddr, wdata); end
        step();
        total++; if (wen !== 1'b0) begin bad++; $display("FAIL order_wen_end got=%0b exp=0", wen); end
        vblank = 1'b0;
    endtask

    task automatic test_full();
        vblank    = 1'b0;
        req_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            req_addr = 16'(i);
            req_data = 16'(200 + i);
            #1;
            if (i < 8) begin
                total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL full_ready i=%0d got=%0b exp=1", i, req_ready); end
            end else begin
                total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL full_ready_9th got=%0b exp=0", req_ready); end
            end
            if (i < 8) step();
        end
        total++; if (count !== 4'd8)   begin bad++; $display("FAIL full_count got=%0d exp=8", count); end
        total++; if (wen !== 1'b0)     begin bad++; $display("FAIL full_wen got=%0b exp=0", wen); end
        vblank = 1'b1;
        for (int k = 0; k < 9; k++) begin
            step();
            if (k == 0) begin
                total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL full_ready_freed got=%0b exp=1", req_ready); end
            end
            if (k == 1) req_valid = 1'b0;
            total++; if (wen !== 1'b1 || waddr !== 16'(k) || wdata !== 16'(200 + k))
                begin bad++; $display("FAIL full_drain k=%0d got=%0b/%0d/%0d exp=1/%0d/%0d", k, wen, waddr, wdata, k, 200 + k); end
        end
        step();
        total++; if (wen !== 1'b0)   begin bad++; $display("FAIL full_drain_end got=%0b exp=0", wen); end
        total++; if (count !== 4'd0) begin bad++; $display("FAIL full_count_end got=%0d exp=0", count); end
        vblank = 1'b0;
    endtask

    task automatic test_back_to_back();
        vblank    = 1'b1;
        req_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            req_addr = 16'(100 + i);
            req_data = 16'(16'h500 + i);
            step();
            total++; if (count !== 4'd1) begin bad++; $display("FAIL b2b_count i=%0d got=%0d exp=1", i, count); end
            if (i >= 1) begin
                total++; if (wen !== 1'b1 || waddr !== 16'(100 + i - 1) || wdata !== 16'(16'h500 + i - 1))
                    begin bad++; $display("FAIL b2b_write i=%0d got=%0b/%0d/%h exp=1/%0d/%h", i, wen, waddr, wdata, 100 + i - 1, 16'h500 + i - 1); end
            end
        end
        req_valid = 1'b0;
        step();
        total++; if (wen !== 1'b1 || waddr !== 16'd119 || wdata !== 16'h513)
            begin bad++; $display("FAIL b2b_last got=%0b/%0d/%h exp=1/119/513", wen, waddr, wdata); end
        total++; if (count !== 4'd0) begin bad++; $display("FAIL b2b_count_end got=%0d exp=0", count); end
        step();
        total++; if (wen !== 1'b0) begin bad++; $display("FAIL b2b_wen_end got=%0b exp=0", wen); end
        vblank = 1'b0;
    endtask

    task automatic test_reset_mid();
        vblank    = 1'b0;
        req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_addr = 16'(10 + i);
            req_data = 16'(300 + i);
            step();
        end
        req_valid = 1'b0;
        total++; if (count !== 4'd4) begin bad++; $display("FAIL rstmid_count_pre got=%0d exp=4", count); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        total++; if (wen !== 1'b0)     begin bad++; $display("FAIL rstmid_wen got=%0b exp=0", wen); end
        total++; if (count !== 4'd0)   begin bad++; $display("FAIL rstmid_count got=%0d exp=0", count); end
        total++; if (waddr !== 16'd0)  begin bad++; $display("FAIL rstmid_waddr got=%0d exp=0", waddr); end
        total++; if (stalled !== 1'b0) begin bad++; $display("FAIL rstmid_stalled got=%0b exp=0", stalled); end
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready got=%0b exp=1", req_ready); end
        vblank = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            total++; if (wen !== 1'b0) begin bad++; $display("FAIL rstmid_stale_issue cyc=%0d got=%0b/%0d exp=0", c, wen, waddr); end
        end
        vblank = 1'b0;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        vblank    = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        req_data  = '0;
        test_reset();
        test_texture();
        test_position_hold();
        test_ordering();
        test_full();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
